song_sequencer: RTL and testbench

Top-level gameplay controller that sequences one song through the note scroller and the hit-scanning/scoring datapath. Drives the beat counter, the beat limit and the 40-bit padded note window. Steps through the song from a synchronous note ROM. Runs a countdown, play, drain and end-of-game sequence, and ends early when the miss count reaches a limit.

---
 rtl/gv_pkg.sv | 35 +++
 rtl/beat_timer.sv | 30 +++
 rtl/song_sequencer.sv | 151 +++++++++++++++
 tb/tb_song_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gv_pkg.sv
// Shared types and constants for the gameplay sequencer: FSM states, window
// geometry, beat-counter width and default beat periods.
package gv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNTDOWN,
        PLAY,
        DRAIN,
        DONE
    } state_t;

    localparam int WINDOW_W = 40;
    localparam int HIT_POS  = 37;
    localparam int CNT_W    = 23;

    localparam logic [CNT_W-1:0] DEF_LIM_SLOW = 23'd3024000;
    localparam logic [CNT_W-1:0] DEF_LIM_MED  = 23'd2520000;
    localparam logic [CNT_W-1:0] DEF_LIM_FAST = 23'd2016000;

    // Speeds 2 and 3 both select the fast period.
    function automatic logic [CNT_W-1:0] lim_for_speed(
        input logic [1:0]       speed,
        input logic [CNT_W-1:0] slow,
        input logic [CNT_W-1:0] med,
        input logic [CNT_W-1:0] fast
    );
        case (speed)
            2'd0:    return slow;
            2'd1:    return med;
            default: return fast;
        endcase
    endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat counter: counts 0..lim-1 while run is high and pause is low, and
// raises wrap on the last count of each period.
module beat_timer
    import gv_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             run,
    input  logic             pause,
    input  logic [CNT_W-1:0] lim,
    output logic [CNT_W-1:0] counter,
    output logic             wrap
);

    always_comb begin
        wrap = run && !pause && (counter == lim - CNT_W'(1));
    end

    // Dropping run clears the count so every game starts from 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            counter <= '0;
        end else if (!run) begin
            counter <= '0;
        end else if (!pause) begin
            counter <= wrap ? '0 : counter + CNT_W'(1);
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Gameplay controller: countdown, note insertion from the song ROM, window
// drain and end-of-game, with an early loss when misses reach the limit.
module song_sequencer
    import gv_pkg::*;
#(
    parameter int               SONG_LEN        = 64,
    parameter logic [CNT_W-1:0] LIM_SLOW        = DEF_LIM_SLOW,
    parameter logic [CNT_W-1:0] LIM_MED         = DEF_LIM_MED,
    parameter logic [CNT_W-1:0] LIM_FAST        = DEF_LIM_FAST,
    parameter int               COUNTDOWN_BEATS = 4,
    parameter logic [7:0]       MISS_LIMIT      = 8'd20
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        start,
    input  logic                        pause,
    input  logic [1:0]                  speed,
    input  logic                        rom_data,
    input  logic [7:0]                  num_misses,
    output logic [$clog2(SONG_LEN)-1:0] rom_addr,
    output logic [CNT_W-1:0]            counter,
    output logic [CNT_W-1:0]            lim,
    output logic [WINDOW_W-1:0]         padded_notes,
    output logic                        step,
    output logic                        playing,
    output logic                        game_over,
    output logic                        won,
    output state_t                      state
);

    localparam int ADDR_W  = $clog2(SONG_LEN);
    localparam int BEAT_W  = $clog2(COUNTDOWN_BEATS + 1);
    localparam int DRAIN_W = $clog2(WINDOW_W);

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(SONG_LEN - 1);
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(COUNTDOWN_BEATS - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(WINDOW_W - 1);

    logic [BEAT_W-1:0]  beat_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               in_game;
    logic               loss;
    logic               run;
    logic               wrap;

    always_comb begin
        in_game = (state == COUNTDOWN) || (state == PLAY) || (state == DRAIN);
        loss    = ((state == PLAY) || (state == DRAIN)) && (num_misses >= MISS_LIMIT);
        // A loss clears the counter on the same edge that enters DONE.
        run     = in_game && !loss;
    end

    always_comb begin
        step = 1'b0;
        if (((state == PLAY) || (state == DRAIN)) && !pause &&
            (counter == lim - CNT_W'(1))) begin
            step = 1'b1;
        end
    end

    beat_timer u_beat_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .run     (run),
        .pause   (pause),
        .lim     (lim),
        .counter (counter),
        .wrap    (wrap)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            lim          <= LIM_SLOW;
            padded_notes <= '0;
            rom_addr     <= '0;
            beat_cnt     <= '0;
            drain_cnt    <= '0;
            playing      <= 1'b0;
            game_over    <= 1'b0;
            won          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lim          <= lim_for_speed(speed, LIM_SLOW, LIM_MED, LIM_FAST);
                        padded_notes <= '0;
                        rom_addr     <= '0;
                        beat_cnt     <= '0;
                        drain_cnt    <= '0;
                        won          <= 1'b0;
                        playing      <= 1'b1;
                        state        <= COUNTDOWN;
                    end
                end
                COUNTDOWN: begin
                    if (wrap) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state <= PLAY;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                PLAY: begin
                    if (loss) begin
                        won       <= 1'b0;
                        playing   <= 1'b0;
                        game_over <= 1'b1;
                        state     <= DONE;
                    end else if (wrap) begin
                        padded_notes <= {padded_notes[WINDOW_W-2:0], rom_data};
                        if (rom_addr == LAST_ADDR) begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (loss) begin
                        won       <= 1'b0;
                        playing   <= 1'b0;
                        game_over <= 1'b1;
                        state     <= DONE;
                    end else if (wrap) begin
                        padded_notes <= {padded_notes[WINDOW_W-2:0], 1'b0};
                        if (drain_cnt == LAST_DRAIN) begin
                            won       <= 1'b1;
                            playing   <= 1'b0;
                            game_over <= 1'b1;
                            state     <= DONE;
                        end else begin
                            drain_cnt <= drain_cnt + DRAIN_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        game_over <= 1'b0;
                        won       <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a 4-slot song and short beat periods.
module tb_song_sequencer;
    import gv_pkg::*;

    logic                clk;
    logic                n_rst;
    logic                start;
    logic                pause;
    logic [1:0]          speed;
    logic                rom_data;
    logic [7:0]          num_misses;
    logic [1:0]          rom_addr;
    logic [CNT_W-1:0]    counter;
    logic [CNT_W-1:0]    lim;
    logic [WINDOW_W-1:0] padded_notes;
    logic                step;
    logic                playing;
    logic                game_over;
    logic                won;
    state_t              state;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t0;
    logic [3:0] exp_q[$];
    logic       rom [4];

    song_sequencer #(
        .SONG_LEN        (4),
        .LIM_SLOW        (23'd8),
        .LIM_MED         (23'd6),
        .LIM_FAST        (23'd4),
        .COUNTDOWN_BEATS (2),
        .MISS_LIMIT      (8'd3)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .pause        (pause),
        .speed        (speed),
        .rom_data     (rom_data),
        .num_misses   (num_misses),
        .rom_addr     (rom_addr),
        .counter      (counter),
        .lim          (lim),
        .padded_notes (padded_notes),
        .step         (step),
        .playing      (playing),
        .game_over    (game_over),
        .won          (won),
        .state        (state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    // scoreboard check
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic pulse_start(input logic [1:0] spd);
        speed = spd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_step(input string tag);
        int n = 0;
        while (step !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, step, 1);
        @(negedge clk);
    endtask

    task automatic wait_state(input state_t s, input string tag);
        int n = 0;
        while (state !== s && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, state, s);
    endtask

    initial begin
        rom[0] = 1'b1; rom[1] = 1'b0; rom[2] = 1'b1; rom[3] = 1'b1;
        rom_data   = 1'b0;
        n_rst      = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        speed      = 2'd0;
        num_misses = 8'd0;
        exp_q = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};

        // 1: reset values, then idle with no start
        repeat (3) @(negedge clk);
        check("rst_counter", counter, 0);
        check("rst_lim", lim, 8);
        check("rst_notes", padded_notes, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_step", step, 0);
        check("rst_playing", playing, 0);
        check("rst_game_over", game_over, 0);
        check("rst_won", won, 0);
        check("rst_state", state, IDLE);
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_state", state, IDLE);
            check("idle_counter", counter, 0);
        end

        // 2: countdown at speed 2
        t0 = cyc + 1;
        pulse_start(2'd2);
        check("cd_lim", lim, 4);
        check("cd_playing", playing, 1);
        for (int i = 0; i < 8; i++) begin
            check("cd_state", state, COUNTDOWN);
            check("cd_counter", counter, i % 4);
            check("cd_step", step, 0);
            @(negedge clk);
        end
        check("play_entry", state, PLAY);
        check("play_counter0", counter, 0);
        @(negedge clk);
        @(negedge clk);
        check("play_no_early_step", step, 0);
        @(negedge clk);
        check("step1", step, 1);
        @(negedge clk);
        check("step1_cycle", cyc - t0, 12);
        check("step1_notes", padded_notes[3:0], exp_q.pop_front());
        check("step1_addr", rom_addr, 1);

        // 3: pause at counter 2
        @(negedge clk);
        @(negedge clk);
        check("pre_pause_counter", counter, 2);
        pause = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("pause_counter", counter, 2);
            check("pause_step", step, 0);
        end
        pause = 1'b0;
        @(negedge clk);
        check("unpause_counter", counter, 3);
        check("unpause_step", step, 1);
        @(negedge clk);
        check("step2_notes", padded_notes[3:0], exp_q.pop_front());
        check("step2_addr", rom_addr, 2);

        // start during PLAY is ignored
        pulse_start(2'd0);
        check("start_in_play_state", state, PLAY);
        check("start_in_play_lim", lim, 4);

        wait_step("step3");
        check("step3_notes", padded_notes[3:0], exp_q.pop_front());
        check("step3_addr", rom_addr, 3);
        wait_step("step4");
        check("step4_notes", padded_notes[3:0], exp_q.pop_front());
        check("step4_addr", rom_addr, 3);
        check("drain_entry", state, DRAIN);

        // 4: drain to completion, tracking the hit position
        for (int s = 5; s <= 44; s++) begin
            wait_step("drain_step");
            check("hit_bit", padded_notes[HIT_POS], (s == 38 || s == 40 || s == 41) ? 1 : 0);
        end
        check("done_state", state, DONE);
        check("done_game_over", game_over, 1);
        check("done_won", won, 1);
        check("done_playing", playing, 0);
        check("done_counter", counter, 0);
        check("done_notes", padded_notes, 0);
        check("done_addr", rom_addr, 3);

        // 5: loss in PLAY, then restart sequence
        pulse_start(2'd0);
        check("restart_idle", state, IDLE);
        check("restart_game_over", game_over, 0);
        pulse_start(2'd1);
        check("g2_state", state, COUNTDOWN);
        check("g2_lim", lim, 6);
        wait_state(PLAY, "g2_play");
        @(negedge clk);
        num_misses = 8'd3;
        @(negedge clk);
        check("loss_state", state, DONE);
        check("loss_won", won, 0);
        check("loss_playing", playing, 0);
        check("loss_game_over", game_over, 1);
        check("loss_counter", counter, 0);
        num_misses = 8'd0;

        // loss while paused in DRAIN
        pulse_start(2'd0);
        pulse_start(2'd3);
        check("g3_lim", lim, 4);
        wait_state(DRAIN, "g3_drain");
        pause      = 1'b1;
        num_misses = 8'd5;
        @(negedge clk);
        check("pause_loss_state", state, DONE);
        check("pause_loss_won", won, 0);
        pause      = 1'b0;
        num_misses = 8'd0;

        // 6: asynchronous reset mid-DRAIN
        pulse_start(2'd0);
        pulse_start(2'd2);
        wait_state(DRAIN, "g4_drain");
        check("g4_notes", padded_notes[3:0], 4'b1011);
        n_rst = 1'b0;
        #1;
        check("arst_state", state, IDLE);
        check("arst_counter", counter, 0);
        check("arst_notes", padded_notes, 0);
        check("arst_addr", rom_addr, 0);
        check("arst_playing", playing, 0);
        check("arst_step", step, 0);
        check("arst_lim", lim, 8);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("post_rst_state", state, IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
